dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache and its controller, placed in the MEM stage between the EX/MEM pipeline register outputs and off-chip data memory. It services CPU loads and stores from internal line storage. On a miss it writes back a dirty victim, refills the line from memory over a req/ack handshake, and raises cpu_stall_o to freeze the pipeline until the access completes.

Parameters:
LINES, 32, number of cache lines (power of 2); index width IW = log2(LINES)
LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset = addr[4:0], word select = addr[4:2]

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
cpu_addr_i  in  32  byte address (ALU result from EX/MEM)
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_i  in  32  store data
cpu_data_o  out  32  load data, valid when cpu_stall_o=0
cpu_stall_o  out  1  freeze pipeline
mem_enable_o  out  1  memory request, level
mem_write_o  out  1  1=write line, 0=read line
mem_addr_o  out  32  line-aligned address ([4:0]=0)
mem_data_o  out  256  writeback line
mem_data_i  in  256  refill line, valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split: tag = addr[31:5+IW], index = addr[4+IW:5], word = addr[4:2]. addr[1:0] is ignored; accesses are word-only.
- Per-line state: valid, dirty, tag, 256-bit data.
- Reset (rst_i=1 at an edge):
  - All valid and dirty bits cleared; state goes to IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0, cpu_stall_o=0.
  - Any in-flight memory transaction is abandoned. A mem_ack_i arriving after reset is ignored.
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are asserted, the access is treated as a write. hit = valid[index] & tag match.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - No req: cpu_stall_o=0.
  - Read hit: cpu_data_o = selected word, combinational; cpu_stall_o=0; zero extra latency.
  - Write hit: selected word replaced at the edge and dirty set; cpu_stall_o=0.
  - Miss: cpu_stall_o=1 combinationally in the same cycle. Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- WRITEBACK:
  - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim line. These are held stable until mem_ack_i.
  - On ack: go to ALLOCATE; the dirty bit stays set until the refill overwrites the line.
- ALLOCATE:
  - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
  - On ack: line <= mem_data_i, tag <= req tag, valid=1, dirty=0; go to IDLE.
  - The replayed access then hits in IDLE and cpu_stall_o drops that cycle. A write miss merges the store there and sets dirty.
- cpu_stall_o=1 throughout WRITEBACK and ALLOCATE. mem_enable_o=0 in IDLE.
- mem_enable_o deasserts in the cycle after the ack. An ack seen in IDLE is ignored.
- Miss latency in stalled cycles: 1 + (cycles to WB ack, if dirty) + (cycles to refill ack).
- Stability requirement: CPU request inputs are held stable by the stalled pipeline. Behaviour is undefined if they change while stalled.
- Replacement: the victim is always the line at index (direct-mapped). Tag compare is a full-width equality; there is no partial matching.

Test Plan:
- Cold read miss: after reset, load from 0x0000_0040 with memory ack 9 cycles after enable, refill word1 = 0xDEAD_BEEF, addr 0x44. Expect: stall high same cycle; mem_addr_o=0x40, write=0; stall drops the cycle after ack (10 stalled cycles total); cpu_data_o=0xDEAD_BEEF.
- Read hit: repeat the load of 0x44 → stall=0, data 0xDEAD_BEEF same cycle, mem_enable_o stays 0.
- Dirty eviction:
  - Store 0x1234_5678 to 0x44 (hit, no stall), then load 0x0000_0444 (same index 2, LINES=32, different tag).
  - Expect a WRITEBACK transaction first: addr 0x40, write=1, mem_data_o[63:32]=0x1234_5678.
  - Then an ALLOCATE transaction at 0x440; finally data from the new line.
- Write miss allocate: store 0xA5A5_A5A5 to a clean, invalid index. Expect:
  - Read-only refill.
  - Stored word merged after refill; dirty set.
  - Subsequent load returns 0xA5A5_A5A5 with no stall.
- Zero-wait memory: ack in the first enable cycle → exactly 2 stalled cycles for a clean miss; a mem_ack_i pulse while IDLE causes no state change.
- Reset mid-refill: assert rst_i during ALLOCATE. Expect:
  - mem_enable_o=0 and stall=0 next cycle.
  - The later ack is ignored.
  - A previously cached address now misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate L1 data cache with
//               req/ack refill and dirty-victim writeback.
// Revision    : 1.0
// ============================================================================
module dcache_ctrl #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - 5 - IW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [TW-1:0]        r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];
  logic                 r_mem_enable;
  logic                 r_mem_write;
  logic [31:0]          r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_data;

  logic [TW-1:0]        w_tag;
  logic [IW-1:0]        w_index;
  logic [2:0]           w_word;
  logic                 w_req;
  logic                 w_hit;
  logic                 w_wr_hit;
  logic                 w_victim_dirty;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_unused;

  assign w_tag          = cpu_addr_i[31:5+IW];
  assign w_index        = cpu_addr_i[4+IW:5];
  assign w_word         = cpu_addr_i[4:2];
  assign w_unused       = ^cpu_addr_i[1:0];
  assign w_req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_wr_hit       = (r_state == S_IDLE) && cpu_MemWrite_i && w_hit;
  assign w_victim_dirty = r_valid[w_index] & r_dirty[w_index];
  assign w_line         = r_data[w_index];

  // Loads return in the same cycle; stores take priority when both are set.
  assign cpu_data_o  = ((r_state == S_IDLE) && w_hit && cpu_MemRead_i && !cpu_MemWrite_i)
                       ? w_line[{w_word, 5'b00000} +: 32] : 32'd0;
  assign cpu_stall_o = (r_state != S_IDLE) || (w_req && !w_hit);

  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

  // Line storage is not reset; validity alone decides whether it is usable.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == S_ALLOCATE && mem_ack_i) begin
        r_data[w_index] <= mem_data_i;
        r_tag[w_index]  <= w_tag;
      end else if (w_wr_hit) begin
        r_data[w_index][{w_word, 5'b00000} +: 32] <= cpu_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_mem_enable <= 1'b1;
            if (w_victim_dirty) begin
              r_state     <= S_WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_index], w_index, 5'b00000};
              r_mem_data  <= w_line;
            end else begin
              r_state     <= S_ALLOCATE;
              r_mem_write <= 1'b0;
              r_mem_addr  <= {w_tag, w_index, 5'b00000};
            end
          end else if (w_wr_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          // Dirty bit is left set; the refill below overwrites the line.
          if (mem_ack_i) begin
            r_state     <= S_ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {w_tag, w_index, 5'b00000};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            r_state          <= S_IDLE;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
            r_mem_enable     <= 1'b0;
            r_mem_write      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl against a line-level
//               cache/memory reference model and a latency-controlled memory.
// Revision    : 1.0
// ============================================================================
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  cpu_addr_i = '0;
  logic         cpu_MemRead_i = 1'b0;
  logic         cpu_MemWrite_i = 1'b0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl #(.LINES(32), .LINE_BITS(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_MemRead_i(cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Memory as the DUT sees it (line-keyed) and the model's own memory image.
  logic [255:0] backing [logic [31:0]];
  logic [31:0]  mmem    [logic [31:0]];
  bit           mv [32];
  bit           md [32];
  logic [21:0]  mt [32];
  logic [255:0] ml [32];

  int              es, os, entx, ontx;
  logic [31:0]     erd, ord;
  logic [1:0][31:0] eta, ota;
  logic [1:0]      etw, otw;
  logic [255:0]    ewb, owb;
  bit              tmo;

  function automatic logic [31:0] base_word(input logic [31:0] a);
    if (a == 32'h44) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [255:0] refill_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base_word(la + 32'(4*i));
    return l;
  endfunction

  function automatic logic [255:0] mm_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] wa;
      wa = la + 32'(4*i);
      l[i*32 +: 32] = mmem.exists(wa) ? mmem[wa] : base_word(wa);
    end
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
  endtask

  // Predicts stall count, memory transactions and load data for one access.
  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                              input int l0, input int l1, output int xs,
                              output logic [31:0] xrd, output int xn,
                              output logic [1:0][31:0] xa, output logic [1:0] xw,
                              output logic [255:0] xwb);
    logic [4:0]  idx;
    logic [21:0] tg;
    logic [31:0] va;
    int          w;
    idx = a[9:5]; tg = a[31:10]; w = int'(a[4:2]);
    xs = 0; xrd = '0; xn = 0; xa = '0; xw = '0; xwb = '0;
    if (!(mv[idx] && mt[idx] == tg)) begin
      xs = 1;
      if (mv[idx] && md[idx]) begin
        va = {mt[idx], idx, 5'b0};
        xa[0] = va; xw[0] = 1'b1; xwb = ml[idx];
        for (int i = 0; i < 8; i++) mmem[va + 32'(4*i)] = ml[idx][i*32 +: 32];
        xs += l0; xn = 1;
      end
      xa[xn] = {tg, idx, 5'b0};
      xw[xn] = 1'b0;
      xs += (xn == 1) ? l1 : l0;
      xn++;
      ml[idx] = mm_line({tg, idx, 5'b0});
      mt[idx] = tg; mv[idx] = 1'b1; md[idx] = 1'b0;
    end
    if (wr) begin ml[idx][w*32 +: 32] = d; md[idx] = 1'b1; end
    else xrd = ml[idx][w*32 +: 32];
  endtask

  // Drives one access and plays memory, acking each transaction after l0/l1 enable cycles.
  task automatic run_access(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                            input int l0, input int l1, output int st, output logic [31:0] rdat,
                            output int n, output logic [1:0][31:0] ta, output logic [1:0] tw,
                            output logic [255:0] wbd, output bit to);
    int cnt;
    @(posedge clk_i); #1;
    cpu_addr_i = a; cpu_MemRead_i = rd; cpu_MemWrite_i = wr; cpu_data_i = d;
    st = 0; rdat = '0; n = 0; ta = '0; tw = '0; wbd = '0; to = 1'b1; cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) begin rdat = cpu_data_o; to = 1'b0; break; end
      st++;
      if (mem_enable_o) begin
        cnt++;
        if (cnt == 1 && n < 2) begin
          ta[n] = mem_addr_o; tw[n] = mem_write_o;
          if (mem_write_o) wbd = mem_data_o;
        end
        if (cnt >= ((n == 0) ? l0 : l1)) begin
          if (mem_write_o) backing[mem_addr_o] = mem_data_o;
          else mem_data_i = refill_line(mem_addr_o);
          mem_ack_i = 1'b1; cnt = 0; n++;
        end
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end
    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b exp 0", cpu_stall_o); end
    n_checks++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin n_errors++; $display("FAIL reset_mem_ctl: got en=%b wr=%b exp 0 0", mem_enable_o, mem_write_o); end
    n_checks++; if (mem_addr_o !== 32'd0 || mem_data_o !== 256'd0) begin n_errors++; $display("FAIL reset_mem_bus: got addr=%h exp 0", mem_addr_o); end
    n_checks++; if (cpu_data_o !== 32'd0) begin n_errors++; $display("FAIL reset_cpu_data: got %h exp 0", cpu_data_o); end
  endtask

  task automatic test_cold_read_miss();
    model_access(32'h44, 1'b0, 32'd0, 9, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h44, 1'b1, 1'b0, 32'd0, 9, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 10) begin n_errors++; $display("FAIL cold_stalls: got %0d exp 10", os); end
    n_checks++; if (ontx !== 1 || ota[0] !== 32'h40 || otw[0] !== 1'b0) begin n_errors++; $display("FAIL cold_txn: got n=%0d addr=%h wr=%b exp 1 00000040 0", ontx, ota[0], otw[0]); end
    n_checks++; if (ord !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL cold_data: got %h exp deadbeef", ord); end
  endtask

  task automatic test_read_hit();
    model_access(32'h44, 1'b0, 32'd0, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h44, 1'b1, 1'b0, 32'd0, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 0 || ontx !== 0) begin n_errors++; $display("FAIL hit_stalls: got %0d txn %0d exp 0 0", os, ontx); end
    n_checks++; if (ord !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL hit_data: got %h exp deadbeef", ord); end
    @(negedge clk_i);
    n_checks++; if (mem_enable_o !== 1'b0) begin n_errors++; $display("FAIL hit_mem_en: got %b exp 0", mem_enable_o); end
  endtask

  task automatic test_dirty_eviction();
    model_access(32'h44, 1'b1, 32'h1234_5678, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h44, 1'b0, 1'b1, 32'h1234_5678, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 0) begin n_errors++; $display("FAIL evict_store_stalls: got %0d exp 0", os); end
    model_access(32'h444, 1'b0, 32'd0, 3, 2, es, erd, entx, eta, etw, ewb);
    run_access(32'h444, 1'b1, 1'b0, 32'd0, 3, 2, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 6) begin n_errors++; $display("FAIL evict_stalls: got %0d exp 6", os); end
    n_checks++; if (ontx !== 2 || ota[0] !== 32'h40 || otw[0] !== 1'b1) begin n_errors++; $display("FAIL evict_wb_txn: got n=%0d addr=%h wr=%b exp 2 00000040 1", ontx, ota[0], otw[0]); end
    n_checks++; if (owb[63:32] !== 32'h1234_5678 || owb !== ewb) begin n_errors++; $display("FAIL evict_wb_data: got word1 %h exp 12345678", owb[63:32]); end
    n_checks++; if (ota[1] !== 32'h440 || otw[1] !== 1'b0) begin n_errors++; $display("FAIL evict_rf_txn: got addr=%h wr=%b exp 00000440 0", ota[1], otw[1]); end
    n_checks++; if (ord !== erd) begin n_errors++; $display("FAIL evict_data: got %h exp %h", ord, erd); end
    model_access(32'h44, 1'b0, 32'd0, 2, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h44, 1'b1, 1'b0, 32'd0, 2, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== es || ord !== 32'h1234_5678) begin n_errors++; $display("FAIL evict_reload: got %h stalls %0d exp 12345678 stalls %0d", ord, os, es); end
  endtask

  task automatic test_write_miss();
    model_access(32'hE4, 1'b1, 32'hA5A5_A5A5, 3, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'hE4, 1'b0, 1'b1, 32'hA5A5_A5A5, 3, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 4) begin n_errors++; $display("FAIL wmiss_stalls: got %0d exp 4", os); end
    n_checks++; if (ontx !== 1 || ota[0] !== 32'hE0 || otw[0] !== 1'b0) begin n_errors++; $display("FAIL wmiss_txn: got n=%0d addr=%h wr=%b exp 1 000000e0 0", ontx, ota[0], otw[0]); end
    model_access(32'hE4, 1'b0, 32'd0, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'hE4, 1'b1, 1'b0, 32'd0, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 0 || ord !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL wmiss_load: got %h stalls %0d exp a5a5a5a5 stalls 0", ord, os); end
    model_access(32'h4E4, 1'b0, 32'd0, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h4E4, 1'b1, 1'b0, 32'd0, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (ontx !== 2 || otw[0] !== 1'b1 || owb[63:32] !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL wmiss_dirty: got n=%0d wr=%b word1=%h exp 2 1 a5a5a5a5", ontx, otw[0], owb[63:32]); end
  endtask

  task automatic test_zero_wait();
    model_access(32'hA0, 1'b0, 32'd0, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'hA0, 1'b1, 1'b0, 32'd0, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 2) begin n_errors++; $display("FAIL zwait_stalls: got %0d exp 2", os); end
    n_checks++; if (ord !== erd) begin n_errors++; $display("FAIL zwait_data: got %h exp %h", ord, erd); end
  endtask

  task automatic test_ack_in_idle();
    @(posedge clk_i); #1 mem_ack_i = 1'b1;
    @(posedge clk_i); #1 mem_ack_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin n_errors++; $display("FAIL idle_ack: got stall=%b en=%b exp 0 0", cpu_stall_o, mem_enable_o); end
    model_access(32'hA0, 1'b0, 32'd0, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'hA0, 1'b1, 1'b0, 32'd0, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 0 || ord !== erd) begin n_errors++; $display("FAIL idle_ack_hit: got %h stalls %0d exp %h stalls 0", ord, os, erd); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    int          op, l0, l1;
    bit          rd, wr;
    for (int k = 0; k < 150; k++) begin
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      rd = (op != 2); wr = (op >= 2);
      d  = $urandom;
      l0 = int'($urandom_range(1, 4)); l1 = int'($urandom_range(1, 4));
      model_access(a, wr, d, l0, l1, es, erd, entx, eta, etw, ewb);
      run_access(a, rd, wr, d, l0, l1, os, ord, ontx, ota, otw, owb, tmo);
      n_checks++; if (tmo || os !== es) begin n_errors++; $display("FAIL rand_stalls[%0d] addr=%h: got %0d exp %0d", k, a, os, es); end
      n_checks++; if (ontx !== entx) begin n_errors++; $display("FAIL rand_ntxn[%0d] addr=%h: got %0d exp %0d", k, a, ontx, entx); end
      for (int t = 0; t < entx; t++) begin
        n_checks++; if (ota[t] !== eta[t] || otw[t] !== etw[t]) begin n_errors++; $display("FAIL rand_txn[%0d.%0d]: got %h/%b exp %h/%b", k, t, ota[t], otw[t], eta[t], etw[t]); end
      end
      if (entx == 2) begin
        n_checks++; if (owb !== ewb) begin n_errors++; $display("FAIL rand_wbdata[%0d]: got %h exp %h", k, owb[63:0], ewb[63:0]); end
      end
      if (!wr) begin
        n_checks++; if (ord !== erd) begin n_errors++; $display("FAIL rand_data[%0d] addr=%h: got %h exp %h", k, a, ord, erd); end
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    int en_seen;
    model_access(32'h3064, 1'b0, 32'd0, 2, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h3064, 1'b1, 1'b0, 32'd0, 2, 1, os, ord, ontx, ota, otw, owb, tmo);
    model_access(32'h3064, 1'b0, 32'd0, 1, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h3064, 1'b1, 1'b0, 32'd0, 1, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os !== 0) begin n_errors++; $display("FAIL rmid_prehit: got %0d stalls exp 0", os); end
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h5100; cpu_MemRead_i = 1'b1;
    en_seen = 0;
    for (int c = 0; c < 50 && en_seen < 3; c++) begin
      @(negedge clk_i);
      if (mem_enable_o) en_seen++;
    end
    n_checks++; if (en_seen !== 3) begin n_errors++; $display("FAIL rmid_enable: got %0d enable cycles exp 3", en_seen); end
    rst_i = 1'b1; cpu_MemRead_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    n_checks++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rmid_after_reset: got en=%b stall=%b exp 0 0", mem_enable_o, cpu_stall_o); end
    @(posedge clk_i); #1 mem_ack_i = 1'b1; mem_data_i = '1;
    @(posedge clk_i); #1 mem_ack_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rmid_late_ack: got en=%b stall=%b exp 0 0", mem_enable_o, cpu_stall_o); end
    model_access(32'h3064, 1'b0, 32'd0, 2, 1, es, erd, entx, eta, etw, ewb);
    run_access(32'h3064, 1'b1, 1'b0, 32'd0, 2, 1, os, ord, ontx, ota, otw, owb, tmo);
    n_checks++; if (tmo || os === 0 || os !== es) begin n_errors++; $display("FAIL rmid_remiss: got %0d stalls exp %0d", os, es); end
    n_checks++; if (ord !== erd) begin n_errors++; $display("FAIL rmid_data: got %h exp %h", ord, erd); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_read_miss();
    test_read_hit();
    test_dirty_eviction();
    test_write_miss();
    test_zero_wait();
    test_ack_in_idle();
    test_random();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
